// File: rtl/div_if.sv
// Start/busy/done handshake and operand/result bus shared by the iterative mul/div units.
interface div_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            signed_mode;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  modport master (
    output start, signed_mode, op_a, op_b,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, signed_mode, op_a, op_b,
    output busy, done, quotient, remainder
  );
endinterface

// File: rtl/div.sv
// Radix-2 restoring divider on operand magnitudes, XLEN cycles per op, sign fix on the last cycle.
// Optional DIV_EARLY_TERM_EN: divide-by-zero or zero dividend completes in one cycle.
module div #(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic resetn,
  div_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(XLEN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] prem_q;
  logic [XLEN-1:0] dvd_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] a_raw_q;
  logic            q_neg_q;
  logic            r_neg_q;
  logic            div0_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;

  logic            accept;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [CW-1:0]   cnt_init;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic            qbit;
  logic [XLEN-1:0] prem_d;
  logic [XLEN-1:0] dvd_d;
  logic [XLEN-1:0] quo_d;
  logic [XLEN-1:0] rem_d;

  always_comb begin
    accept = bus.start & ~busy_q;
    mag_a  = (bus.signed_mode & bus.op_a[XLEN-1]) ? -bus.op_a : bus.op_a;
    mag_b  = (bus.signed_mode & bus.op_b[XLEN-1]) ? -bus.op_b : bus.op_b;
`ifdef DIV_EARLY_TERM_EN
    cnt_init = ((bus.op_b == '0) || (bus.op_a == '0)) ? CNT_ONE : CNT_FULL;
`else
    cnt_init = CNT_FULL;
`endif

    // XLEN+1-bit trial subtraction; its MSB is the borrow, so |MIN| is handled exactly.
    shifted = {prem_q, dvd_q[XLEN-1]};
    trial   = shifted - {1'b0, dvs_q};
    qbit    = ~trial[XLEN];
    prem_d  = qbit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    dvd_d   = {dvd_q[XLEN-2:0], qbit};

    if (div0_q) begin
      quo_d = '1;
      rem_d = a_raw_q;
    end else begin
      quo_d = q_neg_q ? -dvd_d  : dvd_d;
      rem_d = r_neg_q ? -prem_d : prem_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      a_raw_q <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      div0_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        busy_q  <= 1'b1;
        count_q <= cnt_init;
        prem_q  <= '0;
        dvd_q   <= mag_a;
        dvs_q   <= mag_b;
        a_raw_q <= bus.op_a;
        q_neg_q <= bus.signed_mode & (bus.op_a[XLEN-1] ^ bus.op_b[XLEN-1]);
        r_neg_q <= bus.signed_mode & bus.op_a[XLEN-1];
        div0_q  <= (bus.op_b == '0);
      end else if (busy_q) begin
        if (count_q == CNT_ONE) begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          quo_q   <= quo_d;
          rem_q   <= rem_d;
          count_q <= '0;
          prem_q  <= '0;
          dvd_q   <= '0;
          dvs_q   <= '0;
          a_raw_q <= '0;
          q_neg_q <= 1'b0;
          r_neg_q <= 1'b0;
          div0_q  <= 1'b0;
        end else begin
          count_q <= count_q - CNT_ONE;
          prem_q  <= prem_d;
          dvd_q   <= dvd_d;
        end
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
endmodule

// File: tb/tb_div.sv
// Randomized and directed checks of div against an arithmetic reference model.
module tb_div;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  div_if #(.XLEN(XLEN)) bus();
  div #(.XLEN(XLEN)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic sm, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sm) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_TERM_EN
    return (a == 32'd0 || b == 32'd0) ? 1 : XLEN;
`else
    return XLEN;
`endif
  endfunction

  // Called on a falling edge; returns on the falling edge where done is seen.
  task automatic run_op(input logic sm, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r,
                        output int lat, output int bcnt);
    int k;
    bus.start = 1'b1; bus.signed_mode = sm; bus.op_a = a; bus.op_b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.signed_mode = 1'($urandom); bus.op_a = $urandom; bus.op_b = $urandom;
    k = 1; bcnt = 0;
    while (bus.done !== 1'b1 && k < 200) begin
      if (bus.busy === 1'b1) bcnt++;
      @(negedge clk);
      k++;
    end
    lat = k - 1;
    q = bus.quotient;
    r = bus.remainder;
  endtask

  task automatic check_op(input string tag, input logic sm, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r, eq, er;
    int lat, bcnt;
    model(sm, a, b, eq, er);
    run_op(sm, a, b, q, r, lat, bcnt);
    chk({tag, "_quo"}, 64'(q), 64'(eq));
    chk({tag, "_rem"}, 64'(r), 64'(er));
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(a, b)));
    chk({tag, "_busycyc"}, 64'(bcnt), 64'(exp_lat(a, b)));
    chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [31:0] q, r, a, b;
    logic sm;
    int lat, bcnt, k, ndone;

    resetn = 1'b0;
    bus.start = 1'b0; bus.signed_mode = 1'b0; bus.op_a = '0; bus.op_b = '0;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_quo", 64'(bus.quotient), 64'd0);
    chk("rst_rem", 64'(bus.remainder), 64'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Directed cases with hand-computed results.
    run_op(1'b0, 32'd100, 32'd7, q, r, lat, bcnt);
    chk("u100_7_quo", 64'(q), 64'd14);
    chk("u100_7_rem", 64'(r), 64'd2);
    chk("u100_7_lat", 64'(lat), 64'd32);
    chk("u100_7_busycyc", 64'(bcnt), 64'd32);
    @(negedge clk);
    chk("done_pulse", 64'(bus.done), 64'd0);
    chk("quo_held", 64'(bus.quotient), 64'd14);

    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, q, r, lat, bcnt);
    chk("sneg7_2_quo", 64'(q), 64'hFFFF_FFFD);
    chk("sneg7_2_rem", 64'(r), 64'hFFFF_FFFF);
    @(negedge clk);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, q, r, lat, bcnt);
    chk("smin_m1_quo", 64'(q), 64'h8000_0000);
    chk("smin_m1_rem", 64'(r), 64'd0);
    @(negedge clk);
    run_op(1'b0, 32'hFFFF_FFFF, 32'h10, q, r, lat, bcnt);
    chk("umax_16_quo", 64'(q), 64'h0FFF_FFFF);
    chk("umax_16_rem", 64'(r), 64'hF);
    @(negedge clk);
    run_op(1'b1, 32'hFFFF_FFFB, 32'd0, q, r, lat, bcnt);
    chk("div0_quo", 64'(q), 64'hFFFF_FFFF);
    chk("div0_rem", 64'(r), 64'hFFFF_FFFB);
    chk("div0_lat", 64'(lat), 64'(exp_lat(32'hFFFF_FFFB, 32'd0)));
    @(negedge clk);

    // A start while busy must not disturb the in-flight op.
    bus.start = 1'b1; bus.signed_mode = 1'b0; bus.op_a = 32'd100; bus.op_b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1;
    repeat (4) begin @(negedge clk); k++; end
    bus.start = 1'b1; bus.op_a = 32'd9; bus.op_b = 32'd3;
    @(negedge clk); k++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    chk("busy_start_lat", 64'(k - 1), 64'd32);
    chk("busy_start_quo", 64'(bus.quotient), 64'd14);
    chk("busy_start_rem", 64'(bus.remainder), 64'd2);
    // Issue the next op on the done cycle.
    check_op("b2b_9_3", 1'b0, 32'd9, 32'd3);
    chk("b2b_quo_lit", 64'(bus.quotient), 64'd3);
    @(negedge clk);

    // Reset mid-operation.
    bus.start = 1'b1; bus.signed_mode = 1'b0; bus.op_a = 32'd100; bus.op_b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_quo", 64'(bus.quotient), 64'd0);
    chk("midrst_rem", 64'(bus.remainder), 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    ndone = 0;
    repeat (40) begin @(negedge clk); if (bus.done === 1'b1) ndone++; end
    chk("midrst_nodone", 64'(ndone), 64'd0);
    run_op(1'b0, 32'd20, 32'd6, q, r, lat, bcnt);
    chk("post_rst_quo", 64'(q), 64'd3);
    chk("post_rst_rem", 64'(r), 64'd2);
    @(negedge clk);

    // Randomized operands across value classes.
    for (int i = 0; i < 60; i++) begin
      sm = 1'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        1: b = $urandom_range(1, 20);
        2: b = 32'd0;
        3: a = 32'd0;
        4: begin sm = 1'b1; a = 32'h8000_0000; b = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'd1; end
        5: begin a = -$urandom_range(0, 1000); b = -$urandom_range(1, 9); end
        default: ;
      endcase
      check_op("rand", sm, a, b);
      if (i % 3 == 0) begin
        @(negedge clk);
        chk("rand_done_pulse", 64'(bus.done), 64'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
